// File: rtl/const_reg_reader.sv
// const_reg_reader: power-on ID check master for the strobe/ack register bus.
// On a start pulse it reads three consecutive ID words at BaseAddr,
// BaseAddr+4 and BaseAddr+8. Each captured word is compared with its expected
// value. The block then reports pass, per-word mismatch and timeout status.
// All outputs are registered. There is no combinational path from iACK/iDAT
// to any output.
module const_reg_reader #(
  parameter logic [31:0] BaseAddr = 32'h0200_0100,
  parameter logic [31:0] EXP_ID1  = 32'h0123_4567,
  parameter logic [31:0] EXP_ID2  = 32'h89AB_CDEF,
  parameter logic [31:0] EXP_ID3  = 32'hFEDC_BA98,
  parameter int unsigned TIMEOUT  = 16
) (
  input  logic        iCLK,
  input  logic        iRST,
  input  logic        iSTART,
  output logic        oBUSY,
  output logic        oDONE,
  output logic        oPASS,
  output logic        oTMO,
  output logic [2:0]  oMISMATCH,
  output logic [31:0] oID1,
  output logic [31:0] oID2,
  output logic [31:0] oID3,
  output logic [31:0] oADR,
  output logic        oSTB,
  output logic        oWE,
  input  logic [31:0] iDAT,
  input  logic        iACK
);

  typedef enum logic [1:0] {
    Idle = 2'd0,
    Req  = 2'd1,
    Gap  = 2'd2,
    Done = 2'd3
  } stateT;

  // Expected words packed so that word k sits at index k.
  localparam logic [2:0][31:0] ExpWords = {EXP_ID3, EXP_ID2, EXP_ID1};
  // Counter value reached after TIMEOUT-1 unacknowledged strobe cycles.
  // The next unacknowledged edge is the TIMEOUT-th one.
  localparam logic [7:0] TmoLast = 8'(TIMEOUT - 1);

  stateT       state;
  logic [1:0]  wordIdx;
  logic [7:0]  tmoCnt;
  logic [2:0]  wordSel;
  logic [2:0]  wordDiff;
  logic [2:0]  mismatchNext;

  // One-hot select of the word being read, and its compare against the
  // expected value. The compare only matters on an acknowledged edge.
  genvar gi;
  generate
    for (gi = 0; gi < 3; gi++) begin : g_word
      assign wordSel[gi]  = (wordIdx == 2'(gi));
      assign wordDiff[gi] = wordSel[gi] & (iDAT != ExpWords[gi]);
    end
  endgenerate

  // Mismatch vector that results if the current word is acknowledged now.
  assign mismatchNext = oMISMATCH | wordDiff;

  // The block never writes.
  assign oWE = 1'b0;

  // Main sequencer. All bus and status outputs are registered here.
  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) begin
      state     <= Idle;
      wordIdx   <= 2'd0;
      tmoCnt    <= 8'd0;
      oSTB      <= 1'b0;
      oADR      <= 32'h0;
      oBUSY     <= 1'b0;
      oDONE     <= 1'b0;
      oPASS     <= 1'b0;
      oTMO      <= 1'b0;
      oMISMATCH <= 3'b000;
      oID1      <= 32'h0;
      oID2      <= 32'h0;
      oID3      <= 32'h0;
    end else begin
      oDONE <= 1'b0;
      case (state)
        Idle: begin
          if (iSTART) begin
            state     <= Req;
            wordIdx   <= 2'd0;
            tmoCnt    <= 8'd0;
            oPASS     <= 1'b0;
            oTMO      <= 1'b0;
            oMISMATCH <= 3'b000;
            oID1      <= 32'h0;
            oID2      <= 32'h0;
            oID3      <= 32'h0;
            oSTB      <= 1'b1;
            oADR      <= BaseAddr;
            oBUSY     <= 1'b1;
          end
        end
        Req: begin
          if (iACK) begin
            if (wordSel[0]) oID1 <= iDAT;
            if (wordSel[1]) oID2 <= iDAT;
            if (wordSel[2]) oID3 <= iDAT;
            oMISMATCH <= mismatchNext;
            oSTB      <= 1'b0;
            oADR      <= 32'h0;
            tmoCnt    <= 8'd0;
            if (wordIdx == 2'd2) begin
              state <= Done;
              oDONE <= 1'b1;
              oPASS <= (mismatchNext == 3'b000);
            end else begin
              wordIdx <= wordIdx + 2'd1;
              state   <= Gap;
            end
          end else if (tmoCnt == TmoLast) begin
            // TIMEOUT strobe cycles without ACK: abandon the rest of the words.
            tmoCnt <= tmoCnt + 8'd1;
            oTMO   <= 1'b1;
            oPASS  <= 1'b0;
            oSTB   <= 1'b0;
            oADR   <= 32'h0;
            oDONE  <= 1'b1;
            state  <= Done;
          end else begin
            tmoCnt <= tmoCnt + 8'd1;
          end
        end
        Gap: begin
          // Single strobe-low cycle between transfers.
          state <= Req;
          oSTB  <= 1'b1;
          oADR  <= BaseAddr + {28'h0, wordIdx, 2'b00};
        end
        Done: begin
          state <= Idle;
          oBUSY <= 1'b0;
        end
        default: begin
          state <= Idle;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_const_reg_reader.sv
// Testbench for const_reg_reader.
// A configurable slave model answers the bus. Each run pushes expected
// results and expected strobe addresses into queues. Independent monitors pop
// those queues and compare them whenever the DUT strobes or pulses oDONE.
module tb_const_reg_reader;

  localparam logic [31:0] BASE = 32'h0200_0100;
  localparam logic [31:0] E1   = 32'h0123_4567;
  localparam logic [31:0] E2   = 32'h89AB_CDEF;
  localparam logic [31:0] E3   = 32'hFEDC_BA98;
  localparam int          TMO  = 16;

  logic        iCLK, iRST, iSTART;
  logic        oBUSY, oDONE, oPASS, oTMO, oSTB, oWE, iACK;
  logic [2:0]  oMISMATCH;
  logic [31:0] oID1, oID2, oID3, oADR, iDAT;

  const_reg_reader #(
    .BaseAddr(BASE), .EXP_ID1(E1), .EXP_ID2(E2), .EXP_ID3(E3), .TIMEOUT(TMO)
  ) dut (
    .iCLK(iCLK), .iRST(iRST), .iSTART(iSTART),
    .oBUSY(oBUSY), .oDONE(oDONE), .oPASS(oPASS), .oTMO(oTMO),
    .oMISMATCH(oMISMATCH), .oID1(oID1), .oID2(oID2), .oID3(oID3),
    .oADR(oADR), .oSTB(oSTB), .oWE(oWE), .iDAT(iDAT), .iACK(iACK)
  );

  initial iCLK = 1'b0;
  always #5 iCLK = ~iCLK;

  int edgeCount = 0;
  always @(posedge iCLK) edgeCount <= edgeCount + 1;

  int compared = 0;
  int mismatched = 0;
  int txnNum = 0;

  typedef struct {
    logic [31:0] id1, id2, id3;
    logic [2:0]  mm;
    logic        pass, tmo;
    int          doneEdge;
  } expT;

  expT         expQ[$];
  logic [31:0] adrQ[$];

  // Slave configuration
  logic [31:0] slvBase;
  logic [31:0] slvData[3];
  int          slvWait[3];
  int          ackWords;
  int          waitCnt = 0;
  int          slvIdx;

  function automatic logic [31:0] expOf(input int k);
    case (k)
      0:       return E1;
      1:       return E2;
      default: return E3;
    endcase
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    compared++;
    if (act !== req) begin
      mismatched++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Slave: decodes three words at slvBase. It acks after slvWait[k] strobe
  // cycles, for the first ackWords words only. Read data is X unless it acks.
  always_comb begin
    iACK   = 1'b0;
    iDAT   = 'x;
    slvIdx = 0;
    if (oSTB && oADR >= slvBase && oADR < slvBase + 32'd12 && oADR[1:0] == 2'b00) begin
      slvIdx = int'((oADR - slvBase) >> 2);
      if (slvIdx < ackWords && waitCnt >= slvWait[slvIdx]) begin
        iACK = 1'b1;
        iDAT = slvData[slvIdx];
      end
    end
  end

  always @(posedge iCLK) begin
    if (!oSTB || iACK) waitCnt <= 0;
    else               waitCnt <= waitCnt + 1;
  end

  // Monitor: completion pulse against the scoreboard.
  initial begin
    forever begin
      @(negedge iCLK);
      if (oDONE) begin
        if (expQ.size() == 0) begin
          chk("unexpected_done", 32'd1, 32'd0);
        end else begin
          expT e;
          e = expQ.pop_front();
          txnNum++;
          chk("id1", oID1, e.id1);
          chk("id2", oID2, e.id2);
          chk("id3", oID3, e.id3);
          chk("mismatch", 32'(oMISMATCH), 32'(e.mm));
          chk("pass", 32'(oPASS), 32'(e.pass));
          chk("tmo", 32'(oTMO), 32'(e.tmo));
          chk("busy_in_done", 32'(oBUSY), 32'd1);
          chk("done_edge", 32'(edgeCount), 32'(e.doneEdge));
          $display("txn %0d: id=%h %h %h mm=%b pass=%b tmo=%b done_edge=%0d",
                   txnNum, oID1, oID2, oID3, oMISMATCH, oPASS, oTMO, edgeCount);
        end
      end
    end
  end

  // Monitor: every strobe start presents the next expected address. The
  // address is zero while the strobe is low, and writes never occur.
  initial begin
    logic prevStb;
    prevStb = 1'b0;
    forever begin
      @(negedge iCLK);
      if (oSTB && !prevStb) begin
        if (adrQ.size() == 0) chk("unexpected_stb", 32'd1, 32'd0);
        else                  chk("stb_addr", oADR, adrQ.pop_front());
      end
      if (!oSTB && oADR != 32'h0) chk("adr_idle_zero", oADR, 32'h0);
      if (oWE) chk("we_never", 32'(oWE), 32'd0);
      prevStb = oSTB;
    end
  end

  task automatic chkReset(input string tag);
    chk({tag, "_stb"}, 32'(oSTB), 32'd0);
    chk({tag, "_we"}, 32'(oWE), 32'd0);
    chk({tag, "_busy"}, 32'(oBUSY), 32'd0);
    chk({tag, "_done"}, 32'(oDONE), 32'd0);
    chk({tag, "_pass"}, 32'(oPASS), 32'd0);
    chk({tag, "_tmo"}, 32'(oTMO), 32'd0);
    chk({tag, "_mm"}, 32'(oMISMATCH), 32'd0);
    chk({tag, "_id1"}, oID1, 32'h0);
    chk({tag, "_id2"}, oID2, 32'h0);
    chk({tag, "_id3"}, oID3, 32'h0);
    chk({tag, "_adr"}, oADR, 32'h0);
  endtask

  // One start: configure the slave, predict the outcome, and pulse iSTART.
  // Optionally pulse extra starts mid-run and on the DONE cycle.
  task automatic runTxn(input logic [31:0] base, input logic [31:0] d0, d1, d2,
                        input int w0, w1, w2, input int aw,
                        input bit midStart, input bit doneStart);
    expT e;
    int  lat;
    int  w[3];
    logic [31:0] d[3];
    logic [31:0] id[3];
    bit  seen, ok;
    @(negedge iCLK);
    slvBase = base;
    slvData[0] = d0; slvData[1] = d1; slvData[2] = d2;
    slvWait[0] = w0; slvWait[1] = w1; slvWait[2] = w2;
    ackWords = aw;
    d[0] = d0; d[1] = d1; d[2] = d2;
    w[0] = w0; w[1] = w1; w[2] = w2;
    // Reference: words are read in order; a word not acked within TMO
    // strobe cycles ends the run.
    e.mm = 3'b000; e.tmo = 1'b0; lat = 0;
    for (int k = 0; k < 3; k++) id[k] = 32'h0;
    for (int k = 0; k < 3; k++) begin
      if (e.tmo) break;
      adrQ.push_back(BASE + 32'(4 * k));
      if (base == BASE && k < aw && w[k] < TMO) begin
        id[k]   = d[k];
        e.mm[k] = (d[k] != expOf(k));
        lat += w[k] + 1 + ((k < 2) ? 1 : 0);
      end else begin
        e.tmo = 1'b1;
        lat += TMO;
      end
    end
    e.id1 = id[0]; e.id2 = id[1]; e.id3 = id[2];
    e.pass = !e.tmo && (e.mm == 3'b000);
    iSTART = 1'b1;
    @(posedge iCLK);
    #1;
    iSTART = 1'b0;
    e.doneEdge = edgeCount + lat;
    expQ.push_back(e);
    seen = 0; ok = 0;
    for (int cyc = 0; cyc < 400; cyc++) begin
      @(negedge iCLK);
      if (seen) begin ok = 1; break; end
      iSTART = (midStart && cyc == 2) || (doneStart && oDONE);
      if (oDONE) seen = 1;
    end
    iSTART = 1'b0;
    if (!ok) begin
      chk("done_within_bound", 32'd0, 32'd1);
      expQ.delete();
      adrQ.delete();
    end else begin
      chk("busy_after_done", 32'(oBUSY), 32'd0);
      chk("pass_held", 32'(oPASS), 32'(e.pass));
      chk("tmo_held", 32'(oTMO), 32'(e.tmo));
      chk("adr_drained", 32'(adrQ.size()), 32'd0);
    end
    repeat (8) @(negedge iCLK);
  endtask

  function automatic logic [31:0] randWord(input int k);
    if ($urandom_range(0, 3) == 0) return expOf(k) ^ (32'h1 << $urandom_range(0, 31));
    return expOf(k);
  endfunction

  function automatic int randWait();
    int r;
    r = int'($urandom_range(0, 9));
    if (r == 7) return TMO - 1;
    if (r == 8) return TMO;
    if (r == 9) return 0;
    return int'($urandom_range(0, 3));
  endfunction

  initial begin
    int rises;
    logic prev;
    iRST = 1'b1; iSTART = 1'b0;
    slvBase = BASE; ackWords = 3;
    slvData[0] = E1; slvData[1] = E2; slvData[2] = E3;
    slvWait[0] = 0; slvWait[1] = 0; slvWait[2] = 0;
    repeat (3) @(negedge iCLK);
    chkReset("reset");
    iRST = 1'b0;
    repeat (2) @(negedge iCLK);

    // Directed scenarios: nominal, bad word 1, wait states, absent slave,
    // and a slave that only answers word 0.
    runTxn(BASE, E1, E2, E3, 0, 0, 0, 3, 0, 0);
    runTxn(BASE, E1, 32'h89AB_CDEE, E3, 0, 0, 0, 3, 0, 0);
    runTxn(BASE, E1, E2, E3, 3, 3, 3, 3, 0, 0);
    runTxn(32'h0200_0200, E1, E2, E3, 0, 0, 0, 3, 0, 0);
    runTxn(BASE, E1, E2, E3, 0, 0, 0, 1, 0, 0);

    // Reset during the second request.
    @(negedge iCLK);
    slvBase = BASE; ackWords = 3;
    slvData[0] = E1; slvData[1] = E2; slvData[2] = E3;
    slvWait[0] = 3; slvWait[1] = 3; slvWait[2] = 3;
    for (int k = 0; k < 3; k++) adrQ.push_back(BASE + 32'(4 * k));
    iSTART = 1'b1;
    @(posedge iCLK);
    #1;
    iSTART = 1'b0;
    rises = 0; prev = 1'b0;
    for (int cyc = 0; cyc < 100; cyc++) begin
      @(negedge iCLK);
      if (oSTB && !prev) rises++;
      prev = oSTB;
      if (rises == 2) break;
    end
    chk("second_req_reached", 32'(rises), 32'd2);
    @(posedge iCLK);
    #2;
    iRST = 1'b1;
    #1;
    chkReset("mid_reset");
    adrQ.delete();
    expQ.delete();
    @(negedge iCLK);
    @(negedge iCLK);
    iRST = 1'b0;
    repeat (2) @(negedge iCLK);
    $display("reset released mid-transfer; rerunning nominal read");
    runTxn(BASE, E1, E2, E3, 0, 0, 0, 3, 1, 1);

    // Randomized runs.
    for (int t = 0; t < 40; t++) begin
      logic [31:0] b;
      int aw;
      b  = ($urandom_range(0, 7) == 0) ? 32'h0200_0200 : BASE;
      aw = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 2)) : 3;
      runTxn(b, randWord(0), randWord(1), randWord(2),
             randWait(), randWait(), randWait(), aw,
             bit'($urandom_range(0, 1)), bit'($urandom_range(0, 1)));
    end

    chk("exp_queue_empty", 32'(expQ.size()), 32'd0);
    chk("adr_queue_empty", 32'(adrQ.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/const_reg_reader.md
Name: const_reg_reader

Overview:
- Bus master that sits directly upstream of the constant/ID register slave on the simple strobe/ack bus (STB, WE, ADR, DAT, ACK).
- On a start pulse it reads three consecutive 32-bit ID words, captures them and compares each against its expected value.
- Reports pass, per-word mismatch and timeout status. Used as the power-on ID check in front of the register block.

Parameters:
- BaseAddr, 32'h0200_0100, address of the first ID word; word k is at BaseAddr + 4*k (k = 0..2).
- EXP_ID1, 32'h0123_4567, expected value of word 0.
- EXP_ID2, 32'h89AB_CDEF, expected value of word 1.
- EXP_ID3, 32'hFEDC_BA98, expected value of word 2.
- TIMEOUT, 16, number of consecutive strobe cycles without ACK before the transfer is aborted (legal range 2..255).

Ports:
- iCLK  in  1  clock; all state changes on the rising edge.
- iRST  in  1  asynchronous, active-high reset.
- iSTART  in  1  start request; sampled only in IDLE.
- oBUSY  out  1  high from the cycle after start is accepted until the DONE cycle inclusive.
- oDONE  out  1  one-cycle completion pulse.
- oPASS  out  1  all three words matched and no timeout occurred.
- oTMO  out  1  a transfer timed out.
- oMISMATCH  out  3  bit k set = word k was read and differs from its expected value.
- oID1, oID2, oID3  out  32 each  captured words 0, 1, 2.
- oADR  out  32  bus address.
- oSTB  out  1  bus strobe.
- oWE  out  1  bus write enable; always 0, because the block only reads.
- iDAT  in  32  bus read data; may be high-Z when iACK = 0.
- iACK  in  1  slave acknowledge; may be combinational from oSTB/oADR.

Behaviour:
- Reset (asynchronous, immediate) forces:
  - State = IDLE; oSTB, oWE, oBUSY, oDONE, oPASS, oTMO = 0.
  - oMISMATCH = 3'b000; oID1..3 = 32'h0; oADR = 32'h0.
  - Word index and timeout counter = 0.
- Reset mid-transfer aborts the transfer the same instant. No partial results are retained.
- States: IDLE, REQ, GAP, DONE. All outputs are registered or decoded from registered state only; there is no combinational path from iACK/iDAT to any output.
- IDLE:
  - oSTB = 0.
  - iSTART = 1 at an edge -> REQ. At that edge: index = 0, timeout counter = 0, oPASS/oTMO/oMISMATCH cleared, oID1..3 cleared to 0.
- REQ:
  - oSTB = 1, oWE = 0, oADR = BaseAddr + 4*index.
  - Edge with iACK = 1: capture iDAT into word[index] and set oMISMATCH[index] = (iDAT != EXP[index]). Then go to DONE if index = 2; otherwise increment index, clear the counter and go to GAP.
  - Edge with iACK = 0: increment the counter. When the counter reaches TIMEOUT (i.e. TIMEOUT strobe cycles without ACK), set oTMO = 1 and go to DONE. The remaining words are not read; their oID stays 0 and their mismatch bit stays 0.
- GAP:
  - oSTB = 0, oADR = 32'h0.
  - Exactly one cycle, then -> REQ. This guarantees a strobe-low cycle between transfers.
- DONE:
  - oSTB = 0 and oDONE = 1 for exactly one cycle.
  - oPASS = ~oTMO & (oMISMATCH == 0), registered on entry to DONE.
  - Then -> IDLE.
- oADR = 32'h0 whenever oSTB = 0.
- iDAT is sampled only on edges where state = REQ and iACK = 1. X or Z on iDAT at other times has no effect.
- Status and captured data hold after DONE until the next accepted start or reset.
- iSTART while not in IDLE (including the DONE cycle) is ignored. It is not queued.
- Latency with a zero-wait slave (ACK in the same cycle as STB): oDONE goes high 5 edges after the edge that accepted iSTART. Each wait cycle adds 1.
- Timeout latency: oSTB stays high for exactly TIMEOUT cycles, then DONE follows.

Test Plan:
1. Default parameters, zero-wait slave with defaults, iSTART pulse:
   - Bus shows oSTB at 0x0200_0100, 0x0200_0104, 0x0200_0108, separated by one-cycle gaps.
   - oID1..3 = 0x01234567 / 0x89ABCDEF / 0xFEDCBA98, oMISMATCH = 000, oPASS = 1, oTMO = 0.
   - oDONE is a single pulse 5 edges after the start edge; oWE is never 1.
2. Slave word 1 = 0x89ABCDEE:
   - oMISMATCH = 3'b010, oPASS = 0, oTMO = 0, oID2 = 0x89ABCDEE.
3. Slave inserts 3 wait cycles per word:
   - Captured values are correct, oPASS = 1.
   - oDONE appears 14 edges after start; iDAT driven X during wait cycles does not corrupt captures.
4. Slave mapped at 0x0200_0200, so no ACK is ever returned:
   - oSTB is high for exactly 16 cycles at 0x0200_0100, then drops.
   - oTMO = 1, oPASS = 0, oMISMATCH = 000, oID1..3 = 0, one oDONE pulse.
5. Slave ACKs word 0 only:
   - Timeout occurs on word 1; oID1 = 0x01234567, oID2 = oID3 = 0, oTMO = 1.
6. Reset and start-while-busy:
   - Assert iRST during the second REQ: oSTB and oBUSY drop immediately, all outputs return to their reset values.
   - After release, an iSTART pulse repeats scenario 1.
   - An extra iSTART during a run and one during the DONE cycle are both ignored: exactly one oDONE per accepted start.
